cam_capture_sequencer: RTL and testbench

// Sequences the MIPI CSI camera capture path from the APB register bank: releases camera reset,

---
 rtl/cam_capture_sequencer.sv | 136 +++++++++++++
 tb/tb_cam_capture_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cam_capture_sequencer.sv
// cam_capture_sequencer: camera bring-up and frame-aligned capture trigger sequencer
module cam_capture_sequencer #(
    parameter int RST_HOLD_CYCLES = 1000,
    parameter int SETTLE_CYCLES   = 10000,
    parameter int TIMEOUT_CYCLES  = 100_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             io_peripheralClk,
    input  logic             io_peripheralReset,
    input  logic             i_enable,
    input  logic             i_mode_continuous,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_frame_limit,
    input  logic             i_dma_init_done,
    input  logic             i_frame_start,
    input  logic             i_frame_done,
    output logic             o_mipi_rstn,
    output logic             o_trigger_capture,
    output logic             o_continuous_capture,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_frames_captured,
    output logic             o_timeout,
    output logic [2:0]       o_state
);
    localparam logic [2:0] S_RESET_HOLD = 3'd0;
    localparam logic [2:0] S_SETTLE     = 3'd1;
    localparam logic [2:0] S_WAIT_DMA   = 3'd2;
    localparam logic [2:0] S_IDLE       = 3'd3;
    localparam logic [2:0] S_ARM        = 3'd4;
    localparam logic [2:0] S_CAPTURE    = 3'd5;
    localparam int M1 = RST_HOLD_CYCLES > SETTLE_CYCLES ? RST_HOLD_CYCLES : SETTLE_CYCLES;
    localparam int MAXC = M1 > TIMEOUT_CYCLES ? M1 : TIMEOUT_CYCLES;
    localparam int TW = $clog2(MAXC + 1);

    logic [TW-1:0]    timer;
    logic             mode_q;
    logic [CNT_W-1:0] limit_q;
    logic             stop_pending;
    logic [CNT_W-1:0] cnt_inc;
    logic             done;
    logic             wd_exp;

    // Saturating frame increment, session-end decision and watchdog expiry
    always_comb begin
        cnt_inc = &o_frames_captured ? o_frames_captured : o_frames_captured + CNT_W'(1);
        done    = !mode_q || stop_pending || i_stop || (limit_q != '0 && cnt_inc == limit_q);
        wd_exp  = timer == TW'(TIMEOUT_CYCLES - 1);
    end

    assign o_busy               = (o_state == S_ARM) || (o_state == S_CAPTURE);
    assign o_continuous_capture = mode_q && o_busy;

    // Sequencer state machine; one shared timer serves hold, settle and watchdog
    always_ff @(posedge io_peripheralClk) begin
        if (io_peripheralReset) begin
            o_state           <= S_RESET_HOLD;
            timer             <= '0;
            o_mipi_rstn       <= 1'b0;
            o_trigger_capture <= 1'b0;
            o_frames_captured <= '0;
            o_timeout         <= 1'b0;
            mode_q            <= 1'b0;
            limit_q           <= '0;
            stop_pending      <= 1'b0;
        end else begin
            o_trigger_capture <= 1'b0;
            if (!i_enable) begin
                o_state     <= S_RESET_HOLD;
                timer       <= '0;
                o_mipi_rstn <= 1'b0;
            end else begin
                case (o_state)
                    S_RESET_HOLD: begin
                        if (timer == TW'(RST_HOLD_CYCLES - 1)) begin
                            o_state     <= S_SETTLE;
                            o_mipi_rstn <= 1'b1;
                            timer       <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (timer == TW'(SETTLE_CYCLES - 1)) begin
                            o_state <= S_WAIT_DMA;
                            timer   <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    S_WAIT_DMA: o_state <= i_dma_init_done ? S_IDLE : S_WAIT_DMA;
                    S_IDLE: begin
                        if (i_start && !i_stop) begin
                            o_state           <= S_ARM;
                            timer             <= '0;
                            mode_q            <= i_mode_continuous;
                            limit_q           <= i_frame_limit;
                            o_frames_captured <= '0;
                            o_timeout         <= 1'b0;
                            stop_pending      <= 1'b0;
                        end
                    end
                    S_ARM: begin
                        if (i_stop) begin
                            o_state <= S_IDLE;
                        end else if (i_frame_start) begin
                            o_state           <= S_CAPTURE;
                            o_trigger_capture <= 1'b1;
                            timer             <= '0;
                        end else if (wd_exp) begin
                            o_state   <= S_IDLE;
                            o_timeout <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    S_CAPTURE: begin
                        if (i_stop) stop_pending <= 1'b1;
                        if (i_frame_done) begin
                            o_frames_captured <= cnt_inc;
                            timer             <= '0;
                            o_state           <= done ? S_IDLE : (i_frame_start ? S_CAPTURE : S_ARM);
                            o_trigger_capture <= !done && i_frame_start;
                        end else if (wd_exp) begin
                            o_state   <= S_IDLE;
                            o_timeout <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: o_state <= S_RESET_HOLD;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cam_capture_sequencer.sv
// tb_cam_capture_sequencer: scoreboard bench for the capture sequencer
module tb_cam_capture_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, mode = 1'b0, start = 1'b0, stop = 1'b0;
    logic [7:0] limit = '0;
    logic       dma = 1'b0, fs = 1'b0, fd = 1'b0;
    logic       rstn, trig, cont, busy, tmo;
    logic [7:0] frames;
    logic [2:0] st;
    int         checks = 0, errors = 0;
    int         exp_q[$];

    cam_capture_sequencer #(
        .RST_HOLD_CYCLES(4), .SETTLE_CYCLES(8), .TIMEOUT_CYCLES(64), .CNT_W(8)
    ) dut (
        .io_peripheralClk(clk), .io_peripheralReset(rst), .i_enable(en),
        .i_mode_continuous(mode), .i_start(start), .i_stop(stop), .i_frame_limit(limit),
        .i_dma_init_done(dma), .i_frame_start(fs), .i_frame_done(fd),
        .o_mipi_rstn(rstn), .o_trigger_capture(trig), .o_continuous_capture(cont),
        .o_busy(busy), .o_frames_captured(frames), .o_timeout(tmo), .o_state(st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input int s, input int budget);
        int k = 0;
        while (int'(st) != s && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, int'(st), s);
    endtask

    // Every trigger pulse must match a queued expectation of the frame count at that moment
    always @(negedge clk) begin
        if (trig) begin
            if (exp_q.size() == 0) chk("unexpected_trigger", 1, 0);
            else begin
                chk("trig_frames", int'(frames), exp_q.pop_front());
                chk("trig_state", int'(st), 5);
            end
        end
    end

    initial begin
        tick(3);
        chk("rst_state", int'(st), 0);
        chk("rst_rstn", int'(rstn), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frames", int'(frames), 0);
        chk("rst_timeout", int'(tmo), 0);
        chk("rst_trig", int'(trig), 0);
        rst = 1'b0;
        en  = 1'b1;
        tick(3);
        chk("hold_rstn", int'(rstn), 0);
        tick(1);
        chk("rel_rstn", int'(rstn), 1);
        chk("settle_state", int'(st), 1);
        tick(8);
        chk("wait_dma_state", int'(st), 2);
        tick(8);
        chk("wait_dma_hold", int'(st), 2);
        dma = 1'b1;
        wait_state("bringup_idle", 3, 5);

        // single-shot
        mode = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        chk("ss_arm", int'(st), 4);
        chk("ss_busy", int'(busy), 1);
        chk("ss_cont", int'(cont), 0);
        tick(4);
        chk("ss_arm_wait", int'(st), 4);
        exp_q.push_back(0);
        fs = 1'b1; tick(1); fs = 1'b0;
        tick(3);
        fd = 1'b1; tick(1); fd = 1'b0;
        chk("ss_idle", int'(st), 3);
        chk("ss_frames", int'(frames), 1);
        chk("ss_busy_done", int'(busy), 0);

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
        chk("startstop_idle", int'(st), 3);

        // continuous, limit 3
        mode = 1'b1; limit = 8'd3;
        start = 1'b1; tick(1); start = 1'b0;
        chk("lim_cont", int'(cont), 1);
        chk("lim_frames_clr", int'(frames), 0);
        for (int i = 0; i < 3; i++) begin
            tick(2);
            exp_q.push_back(i);
            fs = 1'b1; tick(1); fs = 1'b0;
            tick(2);
            fd = 1'b1; tick(1); fd = 1'b0;
            chk("lim_state", int'(st), i < 2 ? 4 : 3);
        end
        chk("lim_frames", int'(frames), 3);
        fs = 1'b1; tick(1); fs = 1'b0;
        chk("lim_no_retrig", int'(st), 3);

        // unlimited: back-to-back re-trigger, then graceful stop
        limit = 8'd0;
        start = 1'b1; tick(1); start = 1'b0;
        exp_q.push_back(0);
        fs = 1'b1; tick(1); fs = 1'b0;
        tick(2);
        fs = 1'b1; tick(1); fs = 1'b0;
        chk("drain_ignore", int'(st), 5);
        exp_q.push_back(1);
        fd = 1'b1; fs = 1'b1; tick(1); fd = 1'b0; fs = 1'b0;
        chk("retrig_state", int'(st), 5);
        chk("retrig_frames", int'(frames), 1);
        stop = 1'b1; tick(1); stop = 1'b0;
        chk("stop_pending_state", int'(st), 5);
        tick(2);
        fd = 1'b1; fs = 1'b1; tick(1); fd = 1'b0; fs = 1'b0;
        chk("stop_idle", int'(st), 3);
        chk("stop_frames", int'(frames), 2);

        // stop in ARM wins over frame_start
        start = 1'b1; tick(1); start = 1'b0;
        stop = 1'b1; fs = 1'b1; tick(1); stop = 1'b0; fs = 1'b0;
        chk("arm_stop", int'(st), 3);

        // watchdog
        mode = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        tick(63);
        chk("wd_pre_state", int'(st), 4);
        chk("wd_pre_flag", int'(tmo), 0);
        tick(1);
        chk("wd_state", int'(st), 3);
        chk("wd_flag", int'(tmo), 1);
        start = 1'b1; tick(1); start = 1'b0;
        chk("wd_clear", int'(tmo), 0);
        chk("wd_rearm", int'(st), 4);
        stop = 1'b1; tick(1); stop = 1'b0;

        // enable drop during capture
        start = 1'b1; tick(1); start = 1'b0;
        exp_q.push_back(0);
        fs = 1'b1; tick(1); fs = 1'b0;
        en = 1'b0; tick(1);
        chk("endrop_state", int'(st), 0);
        chk("endrop_rstn", int'(rstn), 0);
        chk("endrop_busy", int'(busy), 0);
        tick(5);
        chk("endrop_held", int'(st), 0);
        en = 1'b1;
        wait_state("reenable_idle", 3, 40);
        chk("reenable_rstn", int'(rstn), 1);

        tick(2);
        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
